// File: rtl/eth_rx_port_arbiter.sv
// -----------------------------------------------------------------------------
// eth_rx_port_arbiter
//
// Merges NUM_PORTS AXI-stream RX lanes into a single output stream. Arbitration
// works on whole packets and is round-robin: once a port is granted, its beats
// pass combinationally to the output until its tlast beat is accepted.
// Ports whose PHY link is down are flushed. Each packet flushed this way is
// counted in a saturating per-port drop counter. Each forwarded packet also
// restarts that port's activity LED hold timer.
//
// Ports
//   clk156          sole clock (156.25 MHz)
//   aresetn         asynchronous active-low reset
//   link_up         per-port PHY link status
//   s_axis_*        flattened RX streams, port i on lane i
//   s_axis_tready   per-port ready (grant pass-through, back-pressure or flush)
//   m_axis_*        merged stream; m_axis_tdest carries the source port
//   drop_count      per-port 16-bit saturating dropped-packet counters
//   led             per-port activity indicators
// -----------------------------------------------------------------------------
module eth_rx_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2,
    parameter int LED_HOLD   = 15625000
) (
    input  logic                               clk156,
    input  logic                               aresetn,
    input  logic [NUM_PORTS-1:0]               link_up,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]               s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]               s_axis_tlast,
    input  logic [NUM_PORTS-1:0]               s_axis_tuser,
    output logic [NUM_PORTS-1:0]               s_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser,
    output logic [ID_WIDTH-1:0]                m_axis_tdest,
    input  logic                               m_axis_tready,
    output logic [NUM_PORTS*16-1:0]            drop_count,
    output logic [NUM_PORTS-1:0]               led
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LED_W      = (LED_HOLD > 0) ? $clog2(LED_HOLD + 1) : 1;

    generate
        if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
            $error("eth_rx_port_arbiter: NUM_PORTS must be 1..8");
        end
        if ((2 ** ID_WIDTH) < NUM_PORTS) begin : g_bad_id
            $error("eth_rx_port_arbiter: ID_WIDTH too narrow for NUM_PORTS");
        end
    endgenerate

    // Saturating increment for the drop counters: they stick at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin successor of a port index.
    function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] grant, grant_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;

    // Reset release is brought into the clock domain through two flops.
    // Assertion is immediate; arbitration and link-down flushing stay
    // disabled until the synchronised release reaches run_en.
    logic [1:0] rst_sync;
    logic       run_en;

    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_en = rst_sync[1];

    // Request scan: first requesting, link-up port at or after rr_ptr.
    logic [NUM_PORTS-1:0] req;
    logic                 scan_hit;
    logic [PTR_W-1:0]     scan_pick;

    assign req = s_axis_tvalid & link_up;

    always_comb begin
        int idx;
        idx       = 0;
        scan_hit  = 1'b0;
        scan_pick = '0;
        // Walk from the farthest candidate back to rr_ptr so the nearest
        // requester is the one left standing.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (req[idx]) begin
                scan_hit  = 1'b1;
                scan_pick = PTR_W'(idx);
            end
        end
    end

    // Output mux: a straight copy of the granted lane while in PASS.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tdest  = '0;
        if (state == PASS) begin
            m_axis_tvalid = s_axis_tvalid[grant];
            m_axis_tdata  = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep  = s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tlast  = s_axis_tlast[grant];
            m_axis_tuser  = s_axis_tuser[grant];
            m_axis_tdest  = ID_WIDTH'(grant);
        end
    end

    logic fwd_last;
    assign fwd_last = (state == PASS) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Per-port ready, flush detection and activity indicators.
    logic [NUM_PORTS-1:0] granted;
    logic [NUM_PORTS-1:0] flush_rdy;
    logic [NUM_PORTS-1:0] flush_last;
    logic [NUM_PORTS-1:0] fwd_last_port;
    logic [15:0]          drop_cnt [NUM_PORTS];
    logic [LED_W-1:0]     hold_cnt [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign granted[gi]       = (state == PASS) && (int'(grant) == gi);
            // A granted port keeps its grant even if its link drops, so the
            // packet in flight finishes before flushing takes over.
            assign flush_rdy[gi]     = !link_up[gi] && !granted[gi] && run_en;
            assign s_axis_tready[gi] = granted[gi] ? m_axis_tready : flush_rdy[gi];
            assign flush_last[gi]    = flush_rdy[gi] && s_axis_tvalid[gi] && s_axis_tlast[gi];
            assign fwd_last_port[gi] = fwd_last && granted[gi];
            assign drop_count[gi*16 +: 16] = drop_cnt[gi];
            assign led[gi]           = (hold_cnt[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                drop_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (flush_last[i]) begin
                    drop_cnt[i] <= sat_inc16(drop_cnt[i]);
                end
            end
        end
    end

    // LED is lit while the hold counter is non-zero; a new packet reloads it.
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (fwd_last_port[i]) begin
                    hold_cnt[i] <= LED_W'(LED_HOLD);
                end else if (hold_cnt[i] != '0) begin
                    hold_cnt[i] <= hold_cnt[i] - LED_W'(1);
                end
            end
        end
    end

    // Arbitration FSM.
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (run_en && scan_hit) begin
                    state_nxt = PASS;
                    grant_nxt = scan_pick;
                end
            end
            PASS: begin
                if (fwd_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_port(grant);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
